ase_fifo_reader: RTL and testbench
==================================

ASE_FIFO_READER -- requirements
Module: ase_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload width in bits.
REQ-002 SHALL have parameter DEPTH_BASE2, default 8, log2 of upstream FIFO depth; sizes the flush watchdog.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  1 = fetch from FIFO permitted.
REQ-006 SHALL have port flush  input  1  single-cycle request to discard all buffered and FIFO-resident data.
REQ-007 SHALL have port fifo_rd_en  output  1  pop strobe to the upstream FIFO.
REQ-008 SHALL have port fifo_data  input  DATA_WIDTH  FIFO read data.
REQ-009 SHALL have port fifo_data_v  input  1  FIFO read-data valid, one cycle after fifo_rd_en.
REQ-010 SHALL have port fifo_empty  input  1  FIFO empty, reflects all pops issued before the current edge.
REQ-011 SHALL have port m_valid  output  1  downstream data valid.
REQ-012 SHALL have port m_data  output  DATA_WIDTH  downstream data.
REQ-013 SHALL have port m_ready  input  1  downstream accept.
REQ-014 SHALL have port flush_done  output  1  one-cycle pulse when flush completes.
REQ-015 SHALL have port pop_count  output  32  words delivered downstream, wrapping.
REQ-016 SHALL have port unexp_err  output  1  sticky: fifo_data_v seen with no read outstanding.

Function
REQ-017 SHALL hold a 2-entry in-order output buffer (head drives m_data/m_valid) and a 0..1 in-flight read counter.
REQ-018 SHALL assert fifo_rd_en only when state=RUN, enable=1, fifo_empty=0 and buffered+in_flight+1 <= 2 after counting this cycle's downstream transfer.
REQ-019 SHALL never assert fifo_rd_en while fifo_empty=1 (no underflow), and in FLUSH shall pop irrespective of enable/occupancy.
REQ-020 SHALL capture fifo_data into the buffer tail on fifo_data_v=1 in RUN; capture and downstream transfer in the same cycle both take effect.
REQ-021 SHALL complete a downstream transfer when m_valid=1 and m_ready=1; m_data/m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-022 SHALL sustain one word per cycle with m_ready held 1 and FIFO non-empty; first-word latency from fifo_empty falling to m_valid = 2 cycles.
REQ-023 SHALL implement states RUN and FLUSH; RUN->FLUSH on flush=1; FLUSH->RUN when fifo_empty=1, in_flight=0 and no fifo_data_v this cycle, pulsing flush_done for exactly that cycle.
REQ-024 SHALL on entering FLUSH clear the buffer and deassert m_valid the next cycle; data returned by fifo_data_v during FLUSH SHALL be discarded.
REQ-025 SHALL ignore flush while already in FLUSH; flush coincident with a handshake counts that transfer, then flushes.
REQ-026 SHALL increment pop_count by 1 per downstream transfer, wrapping 0xFFFFFFFF->0.
REQ-027 SHALL set unexp_err when fifo_data_v=1 and in_flight=0; cleared only by reset; the stray word is dropped.
REQ-028 SHALL, on enable falling, stop new pops but continue delivering buffered and in-flight data.

Reset
REQ-029 SHALL on rst_n=0 immediately force: state=RUN, buffer empty, in_flight=0, fifo_rd_en=0, m_valid=0, m_data=0, flush_done=0, pop_count=0, unexp_err=0.
REQ-030 SHALL resume normal operation on the first rising edge after rst_n deasserts; reset mid-transfer discards in-flight data without setting unexp_err.

Verification
REQ-031 SHALL verify streaming: FIFO preloaded 0x1..0x10, enable=1, m_ready=1 -> 16 in-order words, one per cycle after 2-cycle latency, pop_count=16.
REQ-032 SHALL verify backpressure: m_ready=0 for 10 cycles mid-stream -> m_data stable, at most 2 buffered + 0 in-flight, fifo_rd_en=0, no loss/duplication.
REQ-033 SHALL verify empty boundary: FIFO holds 1 word -> exactly one fifo_rd_en pulse, never asserted with fifo_empty=1.
REQ-034 SHALL verify flush: 200 words queued, 2 buffered, flush pulse -> m_valid=0 next cycle, FIFO drained, single flush_done, pop_count unchanged.
REQ-035 SHALL verify unexp_err: fifo_data_v forced with no read pending -> unexp_err=1 until rst_n=0.
REQ-036 SHALL verify async reset asserted mid-stream between edges -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/ase_fifo_reader.sv
// ase_fifo_reader: drains an upstream first-word-fall-through-less FIFO (one-cycle read latency)
// into a 2-entry output buffer presented as a valid/ready stream.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              1 = popping from the FIFO is permitted
//   flush               single-cycle request to discard buffered and FIFO-resident data
//   fifo_rd_en          pop strobe to the FIFO (combinational)
//   fifo_data(_v)       FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty          FIFO empty, already reflecting pops before the current edge
//   m_valid/m_data      downstream stream, head of the output buffer
//   m_ready             downstream accept
//   flush_done          one-cycle pulse on the cycle the flush completes
//   pop_count           wrapping count of words delivered downstream
//   unexp_err           sticky: read data returned with no read outstanding
module ase_fifo_reader #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH_BASE2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_data_v,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  flush_done,
  output logic [31:0]           pop_count,
  output logic                  unexp_err
);

  // Watchdog spans four times the FIFO depth: a full FIFO drains well within it.
  localparam int unsigned WdogW = DEPTH_BASE2 + 2;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            count_q, count_d;
  logic                  in_flight_q, in_flight_d;
  logic                  active_q;
  logic [31:0]           pop_count_q, pop_count_d;
  logic                  unexp_err_q, unexp_err_d;
  logic [WdogW-1:0]      wdog_q, wdog_d;

  logic                  xfer;
  logic                  stray;
  logic                  capture;
  logic                  wdog_expired;
  logic                  flush_exit;
  logic [2:0]            occupancy;

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = buf0_q;
  assign pop_count = pop_count_q;
  assign unexp_err = unexp_err_q;

  always_comb begin
    xfer         = m_valid && m_ready;
    stray        = fifo_data_v && !in_flight_q;
    capture      = fifo_data_v && in_flight_q && (state_q == StRun);
    wdog_expired = &wdog_q;
    // Slots claimed after this cycle's transfer, including the read we would issue now.
    occupancy    = {1'b0, count_q} - {2'b00, xfer} + {2'b00, in_flight_q} + 3'd1;
    // A stuck non-empty FIFO must not hold us in flush forever: once the watchdog
    // expires, stop popping and leave as soon as the last read has returned.
    flush_exit   = (state_q == StFlush) && !in_flight_q && !fifo_data_v &&
                   (fifo_empty || wdog_expired);

    // active_q keeps the combinational pop strobe low until the first edge after reset.
    fifo_rd_en = 1'b0;
    if (active_q && !fifo_empty) begin
      if (state_q == StFlush) begin
        fifo_rd_en = !wdog_expired;
      end else begin
        fifo_rd_en = enable && (occupancy <= 3'd2);
      end
    end

    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = count_q;
    if (xfer) begin
      buf0_d  = buf1_q;
      count_d = count_q - 2'd1;
    end
    if (capture && (count_d != 2'd2)) begin
      if (count_d == 2'd0) begin
        buf0_d = fifo_data;
      end else begin
        buf1_d = fifo_data;
      end
      count_d = count_d + 2'd1;
    end

    state_d    = state_q;
    wdog_d     = wdog_q;
    flush_done = 1'b0;
    unique case (state_q)
      StRun: begin
        if (flush) begin
          state_d = StFlush;
          count_d = 2'd0;
          wdog_d  = '0;
        end
      end
      StFlush: begin
        if (!wdog_expired) begin
          wdog_d = wdog_q + WdogW'(1);
        end
        if (flush_exit) begin
          state_d    = StRun;
          flush_done = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase

    in_flight_d = fifo_rd_en;
    pop_count_d = pop_count_q + {31'd0, xfer};
    unexp_err_d = unexp_err_q | stray;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      buf0_q      <= '0;
      buf1_q      <= '0;
      count_q     <= 2'd0;
      in_flight_q <= 1'b0;
      active_q    <= 1'b0;
      pop_count_q <= 32'd0;
      unexp_err_q <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      active_q    <= 1'b1;
      pop_count_q <= pop_count_d;
      unexp_err_q <= unexp_err_d;
      wdog_q      <= wdog_d;
    end
  end

endmodule

// File: tb/tb_ase_fifo_reader.sv
// Directed testbench for ase_fifo_reader with a behavioural one-cycle-latency FIFO.
module tb_ase_fifo_reader;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        fifo_rd_en;
  logic [63:0] fifo_data;
  logic        fifo_data_v;
  logic        fifo_empty;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_ready;
  logic        flush_done;
  logic [31:0] pop_count;
  logic        unexp_err;

  int vectors;
  int miscompares;

  logic [63:0] fq[$];

  // Values sampled on the falling edge by step().
  logic        s_rd;
  logic        s_mv;
  logic [63:0] s_md;
  logic        s_fd;
  logic        s_ue;
  int          underflow;

  ase_fifo_reader #(
    .DATA_WIDTH (64),
    .DEPTH_BASE2(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .flush      (flush),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_data_v(fifo_data_v),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .flush_done (flush_done),
    .pop_count  (pop_count),
    .unexp_err  (unexp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Sample outputs at the falling edge, then model the FIFO 1 ns after the rising edge.
  task automatic step();
    @(negedge clk);
    s_rd = fifo_rd_en;
    s_mv = m_valid;
    s_md = m_data;
    s_fd = flush_done;
    s_ue = unexp_err;
    if (fifo_rd_en && fifo_empty) underflow++;
    @(posedge clk);
    #1;
    if (s_rd && fq.size() > 0) begin
      fifo_data   = fq.pop_front();
      fifo_data_v = 1'b1;
    end else begin
      fifo_data_v = 1'b0;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; m_ready = 1'b1;
    fifo_data = '0; fifo_data_v = 1'b0;
    fq.push_back(64'h55);
    fifo_empty = 1'b0;
    #12;
    vectors++;
    if (fifo_rd_en !== 1'b0) begin
      $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); miscompares++;
    end
    vectors++;
    if (m_valid !== 1'b0 || m_data !== 64'd0) begin
      $display("FAIL reset_m: got v=%b d=%0h expected v=0 d=0", m_valid, m_data); miscompares++;
    end
    vectors++;
    if (flush_done !== 1'b0 || pop_count !== 32'd0 || unexp_err !== 1'b0) begin
      $display("FAIL reset_status: got fd=%b pc=%0d ue=%b expected 0 0 0",
               flush_done, pop_count, unexp_err);
      miscompares++;
    end
    @(posedge clk);
    #1;
    fq.delete();
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_streaming();
    int exp_w = 1;
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) fq.push_back(64'(i));
    fifo_empty = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (s_mv) begin
        vectors++;
        if (s_md !== 64'(exp_w) || k != exp_w + 2) begin
          $display("FAIL stream_word: got %0h at step %0d expected %0h at step %0d",
                   s_md, k, exp_w, exp_w + 2);
          miscompares++;
        end
        exp_w++;
      end
    end
    vectors++;
    if (exp_w != 17) begin
      $display("FAIL stream_count: got %0d words expected 16", exp_w - 1); miscompares++;
    end
    vectors++;
    if (pop_count !== 32'd16) begin
      $display("FAIL stream_pop_count: got %0d expected 16", pop_count); miscompares++;
    end
  endtask

  task automatic test_backpressure();
    int exp_w = 17;
    int got = 0;
    logic [63:0] hold;
    m_ready = 1'b1;
    for (int i = 17; i <= 40; i++) fq.push_back(64'(i));
    fifo_empty = 1'b0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      step();
      if (s_mv) begin
        vectors++;
        if (s_md !== 64'(exp_w)) begin
          $display("FAIL bp_pre_word: got %0h expected %0h", s_md, exp_w); miscompares++;
        end
        exp_w++;
        got++;
      end
    end
    m_ready = 1'b0;
    hold = 64'(exp_w);
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (s_mv !== 1'b1 || s_md !== hold || s_rd !== 1'b0) begin
        $display("FAIL bp_stall: got v=%b d=%0h rd=%b expected v=1 d=%0h rd=0",
                 s_mv, s_md, s_rd, hold);
        miscompares++;
      end
    end
    m_ready = 1'b1;
    for (int k = 0; k < 60 && exp_w <= 40; k++) begin
      step();
      if (s_mv) begin
        vectors++;
        if (s_md !== 64'(exp_w)) begin
          $display("FAIL bp_post_word: got %0h expected %0h", s_md, exp_w); miscompares++;
        end
        exp_w++;
      end
    end
    step();
    step();
    vectors++;
    if (exp_w != 41 || pop_count !== 32'd40) begin
      $display("FAIL bp_total: got next=%0d pc=%0d expected next=41 pc=40", exp_w, pop_count);
      miscompares++;
    end
  endtask

  task automatic test_empty_boundary();
    int pulses = 0;
    int rx = 0;
    m_ready = 1'b1;
    underflow = 0;
    fq.push_back(64'hAB);
    fifo_empty = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (s_rd) pulses++;
      if (s_mv) begin
        rx++;
        vectors++;
        if (s_md !== 64'hAB) begin
          $display("FAIL empty_word: got %0h expected ab", s_md); miscompares++;
        end
      end
    end
    vectors++;
    if (pulses != 1 || rx != 1) begin
      $display("FAIL empty_pulses: got rd=%0d rx=%0d expected 1 1", pulses, rx); miscompares++;
    end
    vectors++;
    if (underflow != 0) begin
      $display("FAIL empty_underflow: got %0d expected 0", underflow); miscompares++;
    end
  endtask

  task automatic test_flush();
    int fd_pulses = 0;
    int mv_seen = 0;
    int after = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 200; i++) fq.push_back(64'h1000 + 64'(i));
    fifo_empty = 1'b0;
    for (int k = 0; k < 6; k++) step();
    vectors++;
    if (s_mv !== 1'b1 || s_md !== 64'h1000) begin
      $display("FAIL flush_pre: got v=%b d=%0h expected v=1 d=1000", s_mv, s_md); miscompares++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    enable = 1'b0;
    step();
    vectors++;
    if (s_mv !== 1'b0) begin
      $display("FAIL flush_mvalid: got %b expected 0", s_mv); miscompares++;
    end
    for (int k = 0; k < 400 && after < 4; k++) begin
      step();
      if (s_fd) fd_pulses++;
      if (s_mv) mv_seen++;
      if (fd_pulses > 0) after++;
    end
    vectors++;
    if (fd_pulses != 1) begin
      $display("FAIL flush_done_pulses: got %0d expected 1", fd_pulses); miscompares++;
    end
    vectors++;
    if (fq.size() != 0 || mv_seen != 0) begin
      $display("FAIL flush_drain: got left=%0d mv=%0d expected 0 0", fq.size(), mv_seen);
      miscompares++;
    end
    vectors++;
    if (pop_count !== 32'd41) begin
      $display("FAIL flush_pop_count: got %0d expected 41", pop_count); miscompares++;
    end
    enable = 1'b1;
  endtask

  task automatic test_unexp_err();
    fifo_data = 64'hDEAD;
    fifo_data_v = 1'b1;
    step();
    step();
    vectors++;
    if (s_ue !== 1'b1 || s_mv !== 1'b0) begin
      $display("FAIL unexp_set: got ue=%b v=%b expected ue=1 v=0", s_ue, s_mv); miscompares++;
    end
    for (int k = 0; k < 3; k++) step();
    vectors++;
    if (s_ue !== 1'b1) begin
      $display("FAIL unexp_sticky: got %b expected 1", s_ue); miscompares++;
    end
  endtask

  task automatic test_async_reset();
    int rx = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) fq.push_back(64'h500 + 64'(i));
    fifo_empty = 1'b0;
    for (int k = 0; k < 5; k++) step();
    vectors++;
    if (s_mv !== 1'b1) begin
      $display("FAIL arst_pre: got v=%b expected 1", s_mv); miscompares++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0 || m_data !== 64'd0 || fifo_rd_en !== 1'b0) begin
      $display("FAIL arst_outputs: got v=%b d=%0h rd=%b expected 0 0 0",
               m_valid, m_data, fifo_rd_en);
      miscompares++;
    end
    vectors++;
    if (pop_count !== 32'd0 || unexp_err !== 1'b0 || flush_done !== 1'b0) begin
      $display("FAIL arst_status: got pc=%0d ue=%b fd=%b expected 0 0 0",
               pop_count, unexp_err, flush_done);
      miscompares++;
    end
    fq.delete();
    fifo_empty = 1'b1;
    fifo_data_v = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    vectors++;
    if (s_ue !== 1'b0 || s_mv !== 1'b0 || pop_count !== 32'd0) begin
      $display("FAIL arst_after: got ue=%b v=%b pc=%0d expected 0 0 0", s_ue, s_mv, pop_count);
      miscompares++;
    end
    fq.push_back(64'h77);
    fq.push_back(64'h78);
    fifo_empty = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_mv) begin
        vectors++;
        if (s_md !== 64'h77 + 64'(rx)) begin
          $display("FAIL arst_resume_word: got %0h expected %0h", s_md, 64'h77 + 64'(rx));
          miscompares++;
        end
        rx++;
      end
    end
    vectors++;
    if (rx != 2 || pop_count !== 32'd2) begin
      $display("FAIL arst_resume: got rx=%0d pc=%0d expected 2 2", rx, pop_count);
      miscompares++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    underflow = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_unexp_err();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
